// File: rtl/voice_allocator.sv
// Voice allocator: maps note-on/off commands onto VOICES slots (retrigger, free, steal via VOICE_STEAL_EN).
// Latency: event strobe VOICES+1 cycles after accept; voice vectors update at the end of that cycle.
// Backpressure: cmd_ready low from accept until COMMIT completes; one command per VOICES+2 cycles.
module voice_allocator #(
  parameter int VOICES = 32,
  parameter int VB     = $clog2(VOICES)
) (
  input  logic              fpga_clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_on,
  input  logic [6:0]        cmd_note,
  input  logic [6:0]        cmd_vel,
  input  logic [VOICES-1:0] voice_done,
  output logic [VOICES-1:0] keys_on,
  output logic [VOICES-1:0] voice_free,
  output logic              evt_valid,
  output logic              evt_gate,
  output logic [VB-1:0]     evt_voice,
  output logic [6:0]        evt_note,
  output logic [6:0]        evt_vel,
  output logic              evt_steal,
  output logic              drop
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SCAN   = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  logic [1:0]    state;
  logic [VB-1:0] scan_idx;
  logic          lat_on;
  logic [6:0]    lat_note;
  logic [6:0]    lat_vel;
  logic          free_found, match_found;
  logic [VB-1:0] free_idx, match_idx;
  logic [6:0]    note_q [VOICES];
  logic          wr_en, wr_hold, wr_load;
  logic [VB-1:0] wr_voice;

  logic          cur_free, cur_match, last_idx;
  logic          nxt_free_found, nxt_match_found;
  logic [VB-1:0] nxt_free_idx, nxt_match_idx;
  logic          dec_evt, dec_hold, dec_load;
  logic [VB-1:0] dec_voice;
`ifdef VOICE_STEAL_EN
  logic [VB-1:0] steal_ptr;
  logic          dec_steal;
`else
  logic          dec_drop;
`endif

  // Fold the voice under the scan index into the running lowest-index picks.
  always_comb begin
    cur_free        = voice_free[scan_idx];
    cur_match       = keys_on[scan_idx] && (note_q[scan_idx] == lat_note);
    last_idx        = (scan_idx == VB'(VOICES - 1));
    nxt_free_found  = free_found;
    nxt_free_idx    = free_idx;
    nxt_match_found = match_found;
    nxt_match_idx   = match_idx;
    if (!free_found && cur_free) begin
      nxt_free_found = 1'b1;
      nxt_free_idx   = scan_idx;
    end
    if (!match_found && cur_match) begin
      nxt_match_found = 1'b1;
      nxt_match_idx   = scan_idx;
    end
  end

  always_comb begin
    dec_evt   = 1'b0;
    dec_hold  = 1'b0;
    dec_load  = 1'b0;
    dec_voice = '0;
`ifdef VOICE_STEAL_EN
    dec_steal = 1'b0;
`else
    dec_drop  = 1'b0;
`endif
    if (lat_on) begin
      if (nxt_match_found) begin
        dec_evt   = 1'b1;
        dec_hold  = 1'b1;
        dec_voice = nxt_match_idx;
      end else if (nxt_free_found) begin
        dec_evt   = 1'b1;
        dec_hold  = 1'b1;
        dec_load  = 1'b1;
        dec_voice = nxt_free_idx;
      end else begin
`ifdef VOICE_STEAL_EN
        dec_evt   = 1'b1;
        dec_hold  = 1'b1;
        dec_load  = 1'b1;
        dec_steal = 1'b1;
        dec_voice = steal_ptr;
`else
        dec_drop  = 1'b1;
`endif
      end
    end else if (nxt_match_found) begin
      dec_evt   = 1'b1;
      dec_voice = nxt_match_idx;
    end
  end

  always_ff @(posedge fpga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cmd_ready   <= 1'b1;
      scan_idx    <= '0;
      lat_on      <= 1'b0;
      lat_note    <= '0;
      lat_vel     <= '0;
      free_found  <= 1'b0;
      free_idx    <= '0;
      match_found <= 1'b0;
      match_idx   <= '0;
      wr_en       <= 1'b0;
      wr_hold     <= 1'b0;
      wr_load     <= 1'b0;
      wr_voice    <= '0;
      evt_valid   <= 1'b0;
      evt_gate    <= 1'b0;
      evt_voice   <= '0;
      evt_note    <= '0;
      evt_vel     <= '0;
    end else begin
      evt_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            lat_on      <= cmd_on;
            lat_note    <= cmd_note;
            lat_vel     <= cmd_vel;
            scan_idx    <= '0;
            free_found  <= 1'b0;
            match_found <= 1'b0;
            cmd_ready   <= 1'b0;
            state       <= SCAN;
          end
        end
        SCAN: begin
          free_found  <= nxt_free_found;
          free_idx    <= nxt_free_idx;
          match_found <= nxt_match_found;
          match_idx   <= nxt_match_idx;
          scan_idx    <= scan_idx + VB'(1);
          if (last_idx) begin
            state     <= COMMIT;
            evt_valid <= dec_evt;
            evt_gate  <= dec_hold;
            evt_voice <= dec_voice;
            evt_note  <= lat_note;
            evt_vel   <= dec_hold ? lat_vel : 7'd0;
            wr_en     <= dec_evt;
            wr_hold   <= dec_hold;
            wr_load   <= dec_load;
            wr_voice  <= dec_voice;
          end
        end
        default: begin
          wr_en     <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Release completions first; the COMMIT write to the same voice overrides them.
  always_ff @(posedge fpga_clk or negedge reset_n) begin
    if (!reset_n) begin
      keys_on    <= '0;
      voice_free <= '1;
      for (int i = 0; i < VOICES; i++) note_q[i] <= '0;
    end else begin
      for (int i = 0; i < VOICES; i++) begin
        if (voice_done[i] && !keys_on[i] && !voice_free[i]) voice_free[i] <= 1'b1;
      end
      if (state == COMMIT && wr_en) begin
        keys_on[wr_voice]    <= wr_hold;
        voice_free[wr_voice] <= 1'b0;
        if (wr_load) note_q[wr_voice] <= lat_note;
      end
    end
  end

`ifdef VOICE_STEAL_EN
  always_ff @(posedge fpga_clk or negedge reset_n) begin
    if (!reset_n) begin
      steal_ptr <= '0;
      evt_steal <= 1'b0;
    end else if (state == SCAN && last_idx) begin
      evt_steal <= dec_steal;
      if (dec_steal) steal_ptr <= steal_ptr + VB'(1);
    end else begin
      evt_steal <= 1'b0;
    end
  end
  assign drop = 1'b0;
`else
  always_ff @(posedge fpga_clk or negedge reset_n) begin
    if (!reset_n) drop <= 1'b0;
    else          drop <= (state == SCAN) && last_idx && dec_drop;
  end
  assign evt_steal = 1'b0;
`endif

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: vector table, hand-written corner sequences and randomized commands vs a slot model.
module tb_voice_allocator;
  localparam int V = 32;

  logic          fpga_clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_on = 1'b0;
  logic [6:0]    cmd_note = '0;
  logic [6:0]    cmd_vel = '0;
  logic [V-1:0]  voice_done = '0;
  logic [V-1:0]  keys_on, voice_free;
  logic          evt_valid, evt_gate, evt_steal, drop;
  logic [4:0]    evt_voice;
  logic [6:0]    evt_note, evt_vel;

  voice_allocator #(.VOICES(V)) dut (
    .fpga_clk(fpga_clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_on(cmd_on),
    .cmd_note(cmd_note), .cmd_vel(cmd_vel), .voice_done(voice_done),
    .keys_on(keys_on), .voice_free(voice_free),
    .evt_valid(evt_valid), .evt_gate(evt_gate), .evt_voice(evt_voice),
    .evt_note(evt_note), .evt_vel(evt_vel), .evt_steal(evt_steal), .drop(drop)
  );

  always #5 fpga_clk = ~fpga_clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slot model: 0 = free, 1 = held, 2 = releasing.
  int ms [V];
  int mn [V];
  int msp;
  int e_valid, e_gate, e_voice, e_vel, e_steal, e_drop;

  function automatic void m_reset();
    for (int i = 0; i < V; i++) begin ms[i] = 0; mn[i] = 0; end
    msp = 0;
  endfunction

  function automatic logic [V-1:0] m_keys();
    logic [V-1:0] r = '0;
    for (int i = 0; i < V; i++) r[i] = (ms[i] == 1);
    return r;
  endfunction

  function automatic logic [V-1:0] m_free();
    logic [V-1:0] r = '0;
    for (int i = 0; i < V; i++) r[i] = (ms[i] == 0);
    return r;
  endfunction

  function automatic void m_predict(input bit on, input int note, input int vel);
    int match = -1;
    int free = -1;
    for (int i = 0; i < V; i++) begin
      if (match < 0 && ms[i] == 1 && mn[i] == note) match = i;
      if (free < 0 && ms[i] == 0) free = i;
    end
    e_valid = 0; e_gate = 0; e_voice = 0; e_vel = 0; e_steal = 0; e_drop = 0;
    if (on) begin
      if (match >= 0)     begin e_valid = 1; e_gate = 1; e_voice = match; e_vel = vel; end
      else if (free >= 0) begin e_valid = 1; e_gate = 1; e_voice = free;  e_vel = vel; end
      else begin
`ifdef VOICE_STEAL_EN
        e_valid = 1; e_gate = 1; e_voice = msp; e_vel = vel; e_steal = 1;
`else
        e_drop = 1;
`endif
      end
    end else if (match >= 0) begin
      e_valid = 1; e_voice = match;
    end
  endfunction

  function automatic void m_done(input logic [V-1:0] mask);
    for (int i = 0; i < V; i++) if (mask[i] && ms[i] == 2) ms[i] = 0;
  endfunction

  function automatic void m_commit(input int note);
    if (e_valid != 0) begin
      ms[e_voice] = (e_gate != 0) ? 1 : 2;
      if (e_gate != 0) mn[e_voice] = note;
      if (e_steal != 0) msp = (msp + 1) % V;
    end
  endfunction

  int         r_valid, r_drop, r_k, r_dk;
  logic       r_gate, r_steal;
  logic [4:0] r_voice;
  logic [6:0] r_note, r_vel;

  task automatic check_vectors(input string tag);
    check({tag, "_keys_on"}, keys_on, m_keys());
    check({tag, "_voice_free"}, voice_free, m_free());
  endtask

  // Issue one command from a negedge; mid_mask pulses voice_done in cycle 5, commit_mask in the COMMIT cycle.
  task automatic do_cmd(input bit on, input int note, input int vel,
                        input logic [V-1:0] mid_mask, input logic [V-1:0] commit_mask);
    int n = 0;
    m_predict(on, note, vel);
    @(negedge fpga_clk);
    while (cmd_ready !== 1'b1 && n < 200) begin @(negedge fpga_clk); n++; end
    if (n >= 200) check("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_on = on; cmd_note = 7'(note); cmd_vel = 7'(vel);
    @(posedge fpga_clk);
    #1 cmd_valid = 1'b0;
    r_valid = 0; r_drop = 0; r_k = 0; r_dk = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge fpga_clk);
      if (evt_valid) begin
        r_valid++; r_k = k;
        r_gate = evt_gate; r_voice = evt_voice; r_note = evt_note; r_vel = evt_vel; r_steal = evt_steal;
      end
      if (drop) begin r_drop++; r_dk = k; end
      if (k == 5) voice_done = mid_mask;
      if (k == 6) voice_done = '0;
      if (k == 33) voice_done = commit_mask;
      if (k == 34) begin
        voice_done = '0;
        check("ready_after_commit", cmd_ready, 1);
      end
    end
    m_done(mid_mask);
    m_done(commit_mask);
    m_commit(note);
    check("evt_count", r_valid, e_valid);
    if (e_valid != 0) begin
      check("evt_cycle", r_k, 33);
      check("evt_gate", r_gate, e_gate);
      check("evt_voice", r_voice, e_voice);
      check("evt_note", r_note, note);
      check("evt_vel", r_vel, e_vel);
      check("evt_steal", r_steal, e_steal);
    end
    check("drop_count", r_drop, e_drop);
    if (e_drop != 0) check("drop_cycle", r_dk, 33);
    check_vectors("post_cmd");
  endtask

  task automatic pulse_done(input logic [V-1:0] mask);
    @(negedge fpga_clk);
    voice_done = mask;
    @(negedge fpga_clk);
    voice_done = '0;
    m_done(mask);
    check_vectors("done_pulse");
  endtask

  task automatic do_reset();
    @(negedge fpga_clk);
    reset_n = 1'b0;
    repeat (3) @(negedge fpga_clk);
    check("rst_keys_on", keys_on, '0);
    check("rst_voice_free", voice_free, {V{1'b1}});
    reset_n = 1'b1;
    @(negedge fpga_clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_evt_valid", evt_valid, 0);
    check("rst_drop", drop, 0);
    m_reset();
  endtask

  typedef struct {
    bit          on;
    int          note;
    int          vel;
    bit          exp_valid;
    bit          exp_gate;
    int          exp_voice;
    logic [31:0] exp_keys;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int nseen;
    tbl[0] = '{1'b1, 60, 100, 1'b1, 1'b1, 0, 32'h1};
    tbl[1] = '{1'b1, 64,  90, 1'b1, 1'b1, 1, 32'h3};
    tbl[2] = '{1'b0, 60,   0, 1'b1, 1'b0, 0, 32'h2};
    tbl[3] = '{1'b1, 64,  50, 1'b1, 1'b1, 1, 32'h2};
    tbl[4] = '{1'b0, 70,   0, 1'b0, 1'b0, 0, 32'h2};
    tbl[5] = '{1'b1, 60,  77, 1'b1, 1'b1, 2, 32'h6};

    m_reset();
    do_reset();

    for (int t = 0; t < 6; t++) begin
      do_cmd(tbl[t].on, tbl[t].note, tbl[t].vel, '0, '0);
      check("tbl_valid", r_valid, tbl[t].exp_valid);
      if (tbl[t].exp_valid) begin
        check("tbl_gate", r_gate, tbl[t].exp_gate);
        check("tbl_voice", r_voice, tbl[t].exp_voice);
      end
      check("tbl_keys", keys_on, tbl[t].exp_keys);
    end

    // Voice 0 is releasing, voice 1 held: only voice 0 may free up.
    pulse_done(32'h3);
    check("done_frees_v0", voice_free[0], 1);
    check("done_ignored_held_v1", keys_on[1], 1);

    // A release finishing on an already-visited voice must not change the pick.
    do_cmd(1'b1, 90, 10, '0, '0);
    do_cmd(1'b0, 64, 0, '0, '0);
    do_cmd(1'b1, 91, 20, 32'h2, '0);
    check("midscan_voice", r_voice, 3);
    check("midscan_v1_freed", voice_free[1], 1);

    do_cmd(1'b1, 92, 30, '0, 32'h2);
    check("commit_vs_done_held", keys_on[1], 1);

    // Pool exhaustion.
    do_reset();
    for (int n = 0; n < V; n++) do_cmd(1'b1, n, 64, '0, '0);
    check("pool_full", keys_on, {V{1'b1}});
    do_cmd(1'b1, 100, 5, '0, '0);
`ifdef VOICE_STEAL_EN
    check("steal1_voice", r_voice, 0);
    check("steal1_flag", r_steal, 1);
    do_cmd(1'b1, 101, 5, '0, '0);
    check("steal2_voice", r_voice, 1);
    do_cmd(1'b0, 2, 0, '0, '0);
    do_cmd(1'b1, 102, 9, '0, 32'h4);
    check("steal_vs_done_voice", r_voice, 2);
    check("steal_vs_done_held", keys_on[2], 1);
`else
    check("full_drop", r_drop, 1);
    check("full_no_evt", r_valid, 0);
    do_cmd(1'b1, 101, 5, '0, '0);
    check("full_drop2", r_drop, 1);
    do_cmd(1'b0, 5, 0, '0, '0);
    pulse_done(32'h20);
    do_cmd(1'b1, 103, 7, '0, '0);
    check("refill_voice", r_voice, 5);
`endif

    // Reset in the middle of a scan.
    do_reset();
    do_cmd(1'b1, 40, 40, '0, '0);
    @(negedge fpga_clk);
    cmd_valid = 1'b1; cmd_on = 1'b1; cmd_note = 7'd50; cmd_vel = 7'd60;
    @(posedge fpga_clk);
    #1 cmd_valid = 1'b0;
    repeat (10) @(negedge fpga_clk);
    reset_n = 1'b0;
    #1;
    check("arst_keys_on", keys_on, '0);
    check("arst_voice_free", voice_free, {V{1'b1}});
    check("arst_evt_valid", evt_valid, 0);
    @(negedge fpga_clk);
    reset_n = 1'b1;
    m_reset();
    @(negedge fpga_clk);
    check("arst_cmd_ready", cmd_ready, 1);
    nseen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge fpga_clk);
      if (evt_valid) nseen++;
    end
    check("arst_no_evt", nseen, 0);
    do_cmd(1'b1, 50, 60, '0, '0);
    check("arst_first_voice", r_voice, 0);

    // Randomized traffic over a narrow note range so matches are frequent.
    for (int it = 0; it < 40; it++) begin
      do_cmd($urandom_range(0, 2) != 0, 60 + int'($urandom_range(0, 7)), int'($urandom_range(1, 127)), '0, '0);
      if ($urandom_range(0, 1) == 1) pulse_done(V'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/voice_allocator.md
# voice_allocator

Voice allocator and scheduler for the polyphonic synthesizer core. It accepts decoded MIDI note-on and note-off commands one at a time and maps each to one of `VOICES` voice slots. Free voices are assigned first, voices already holding the same note are retriggered, and voices are stolen when the pool is exhausted. It drives the per-voice `keys_on` and `voice_free` vectors, and issues a one-cycle gate event per command to the oscillator/envelope datapath.

## Interface
Parameters:
- `VOICES`, 32: number of voice slots; must be a power of two, 2..64.
- `VB`, $clog2(VOICES): voice index width.

Ports:
- `fpga_clk` in, 1: sole clock.
- `reset_n` in, 1: asynchronous, active-low reset.
- `cmd_valid` in, 1: command present.
- `cmd_ready` out, 1: block can accept a command. A command transfers when both `cmd_valid` and `cmd_ready` are high.
- `cmd_on` in, 1: 1 = note-on, 0 = note-off.
- `cmd_note` in, 7: MIDI note number.
- `cmd_vel` in, 7: velocity; ignored for note-off.
- `voice_done` in, VOICES: per-voice one-cycle pulse from the envelope, meaning release has finished.
- `keys_on` out, VOICES: voice is gated (held).
- `voice_free` out, VOICES: voice is idle and allocatable.
- `evt_valid` out, 1: one-cycle event strobe.
- `evt_gate` out, 1: 1 = gate on, 0 = gate off.
- `evt_voice` out, VB: target voice.
- `evt_note` out, 7: note of the event.
- `evt_vel` out, 7: velocity of the event.
- `evt_steal` out, 1: event took a voice that was not free.
- `drop` out, 1: one-cycle pulse when a note-on is discarded.

## Operation
- Each voice is in exactly one of three states:
  - FREE: `voice_free`=1, `keys_on`=0.
  - HELD: `keys_on`=1, `voice_free`=0.
  - RELEASING: both 0.
- Each voice stores a 7-bit note register.
- FSM states: IDLE, SCAN, COMMIT. `cmd_ready` is high only in IDLE.
- IDLE → SCAN on accept. The command fields are latched at accept, and the scan index is set to 0.
- SCAN examines one voice per cycle, indices 0..VOICES-1, and records:
  - the lowest-index FREE voice;
  - the lowest-index HELD voice whose note equals the latched note.
- After index VOICES-1 the FSM moves to COMMIT.
- COMMIT for a note-on, first applicable rule wins:
  1. A matching HELD voice exists: retrigger it. `evt_gate`=1, `evt_steal`=0, voice stays HELD.
  2. A FREE voice exists: take it. Voice → HELD, note register loaded, `evt_steal`=0.
  3. Otherwise: steal the voice at `steal_ptr`. Voice → HELD, note register loaded, `evt_steal`=1, `steal_ptr` increments modulo VOICES.
- COMMIT for a note-off:
  - A matching HELD voice exists: voice → RELEASING, `evt_gate`=0, `evt_vel`=0.
  - No match: no event, no state change.
- COMMIT → IDLE unconditionally.
- `voice_done[i]` moves voice i from RELEASING to FREE. A pulse on a FREE or HELD voice is ignored.
- If COMMIT writes voice i in the same cycle as `voice_done[i]`, the COMMIT write wins.
- Several `voice_done` bits may be set in the same cycle; all are applied.
- Reset, asynchronous and at any time including mid-SCAN, forces:
  - all voices FREE (`voice_free` = all ones, `keys_on` = 0);
  - all note registers = 0;
  - `steal_ptr` = 0;
  - FSM = IDLE;
  - `evt_*`, `drop` = 0;
  - `cmd_ready` = 1 after reset release.
- A command in flight at reset is lost.

## Timing
- All outputs are registered.
- Accept at rising edge T. SCAN occupies T+1..T+VOICES. COMMIT is cycle T+VOICES+1:
  - `evt_*` is valid for exactly that one cycle;
  - `keys_on`/`voice_free` update at the end of that cycle.
- `cmd_ready` returns high in cycle T+VOICES+2. Throughput is one command per VOICES+2 cycles.
- `voice_done` changes are visible on `voice_free` one cycle after the pulse, in any FSM state.
- The scan sees voice state as of the cycle the index is visited. A `voice_done` on an already-visited index does not change the current decision.

## Configuration
- `VOICE_STEAL_EN` defined: rule 3 (stealing) is active, and `drop` is tied 0.
- `VOICE_STEAL_EN` undefined:
  - no FREE voice and no match → no event, `drop` pulses for one cycle in COMMIT;
  - `evt_steal` is tied 0;
  - `steal_ptr` is not built.

## Test plan
- After reset, note-on 60 vel 100 → `evt_valid` at acceptance+33 (VOICES=32), voice 0, `evt_gate`=1; `keys_on`=0x00000001; `voice_free`=0xFFFFFFFE.
- Note-on 60, then note-on 64, then note-off 60 → voices 0 and 1 held; note-off gives `evt_voice`=0, `evt_gate`=0; `keys_on`=0x2.
- Repeat note-on 60 while voice 0 holds 60 → retrigger voice 0, `evt_steal`=0, `keys_on` unchanged.
- 32 distinct note-ons, then note 100 → with `VOICE_STEAL_EN`: voice 0, `evt_steal`=1; a 34th note → voice 1. Without the macro: `drop`=1, no `evt_valid`.
- Note-off 60 on voice 0 → RELEASING; `voice_done[0]` pulse → `voice_free[0]`=1 next cycle. `voice_done[0]` in the same cycle as a COMMIT to voice 0 → voice 0 ends HELD.
- `reset_n` low mid-SCAN → immediately `keys_on`=0, `voice_free`=all ones, no `evt_valid`; `cmd_ready`=1 after release.
